// File: rtl/bresenham_line.sv
// bresenham_line
//   Rasterises the straight line from p to q with the integer Bresenham
//   algorithm and streams its pixels, in order from p toward q, over a
//   valid/ready handshake. One pixel per cycle when the consumer is always
//   ready.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   start      : one-cycle request to draw a line (accepted only in IDLE)
//   p_x, p_y   : line start point, sampled with start
//   q_x, q_y   : line end point, sampled with start
//   pix_x/y    : current pixel coordinate (0 whenever pix_valid is low)
//   pix_valid  : pix_x/pix_y hold a pixel to be written
//   pix_ready  : consumer accepts the pixel this cycle
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse after the last pixel has been accepted
module bresenham_line #(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] p_x,
  input  logic [COORD_W-1:0] p_y,
  input  logic [COORD_W-1:0] q_x,
  input  logic [COORD_W-1:0] q_y,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               busy,
  output logic               done
);

  // Two guard bits: |q-p| needs one extra magnitude bit plus a sign bit,
  // and the error term never exceeds the span of dx + |dy|.
  localparam int EW = COORD_W + 2;

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0] px_r, py_r, qx_r, qy_r;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [COORD_W-1:0] cur_x_nxt, cur_y_nxt;
  logic signed [EW-1:0] dx, dy, err, err_nxt;
  logic signed [EW-1:0] abs_x, abs_y;
  logic signed [EW-1:0] add_x, add_y;
  logic signed [EW:0]   e2, dx_e, dy_e;
  logic sx_neg, sy_neg;
  logic step_x, step_y;
  logic at_end;
  logic handshake;

  function automatic logic signed [EW-1:0] abs_diff(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    logic signed [EW-1:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    return (d < 0) ? -d : d;
  endfunction

  // Step decision uses the pre-update error for both axes.
  always_comb begin
    abs_x     = abs_diff(qx_r, px_r);
    abs_y     = abs_diff(qy_r, py_r);
    e2        = $signed({err, 1'b0});
    dx_e      = $signed({dx[EW-1], dx});
    dy_e      = $signed({dy[EW-1], dy});
    step_x    = (e2 >= dy_e);
    step_y    = (e2 <= dx_e);
    add_x     = step_x ? dy : '0;
    add_y     = step_y ? dx : '0;
    err_nxt   = err + add_x + add_y;
    cur_x_nxt = cur_x;
    cur_y_nxt = cur_y;
    if (step_x) cur_x_nxt = sx_neg ? (cur_x - 1'b1) : (cur_x + 1'b1);
    if (step_y) cur_y_nxt = sy_neg ? (cur_y - 1'b1) : (cur_y + 1'b1);
    at_end    = (cur_x == qx_r) && (cur_y == qy_r);
    handshake = (state == DRAW) && pix_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_valid = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = INIT;
      end
      INIT: state_nxt = DRAW;
      DRAW: begin
        pix_valid = 1'b1;
        pix_x     = cur_x;
        pix_y     = cur_y;
        if (handshake && at_end) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_r   <= '0;
      py_r   <= '0;
      qx_r   <= '0;
      qy_r   <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            px_r <= p_x;
            py_r <= p_y;
            qx_r <= q_x;
            qy_r <= q_y;
          end
        end
        INIT: begin
          dx     <= abs_x;
          dy     <= -abs_y;
          err    <= abs_x - abs_y;
          sx_neg <= !(px_r < qx_r);
          sy_neg <= !(py_r < qy_r);
          cur_x  <= px_r;
          cur_y  <= py_r;
        end
        DRAW: begin
          if (handshake && !at_end) begin
            cur_x <= cur_x_nxt;
            cur_y <= cur_y_nxt;
            err   <= err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_line.sv
module tb_bresenham_line;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] p_x, p_y, q_x, q_y;
  logic [W-1:0] pix_x, pix_y;
  logic         pix_valid;
  logic         pix_ready;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  bresenham_line #(.COORD_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .p_x       (p_x),
    .p_y       (p_y),
    .q_x       (q_x),
    .q_y       (q_y),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Observed word: {pix_valid, busy, done, pix_x, pix_y}
  function automatic logic [2*W+2:0] obs();
    return {pix_valid, busy, done, pix_x, pix_y};
  endfunction

  function automatic logic [2*W+2:0] word(input logic [2:0] flags, input int x, input int y);
    logic [W-1:0] xv, yv;
    xv = x[W-1:0];
    yv = y[W-1:0];
    return {flags, xv, yv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2*W+2:0] o, input logic [2*W+2:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed v/b/d=%b x=%0d y=%0d, expected v/b/d=%b x=%0d y=%0d",
             tag, o[2*W+2:2*W], o[2*W-1:W], o[W-1:0], e[2*W+2:2*W], e[2*W-1:W], e[W-1:0]);
    end
  endtask

  // Pulse start, check the INIT cycle, leave the DUT in its first DRAW cycle.
  task automatic begin_line(input int ax, input int ay, input int bx, input int by);
    p_x = ax[W-1:0]; p_y = ay[W-1:0];
    q_x = bx[W-1:0]; q_y = by[W-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("init", obs(), word(3'b010, 0, 0));
    tick();
  endtask

  // Expect pixel (x,y) offered now; pix_ready is high so it is accepted.
  task automatic exp_pix(input string tag, input int x, input int y);
    chk(tag, obs(), word(3'b110, x, y));
    tick();
  endtask

  task automatic exp_done(input string tag);
    chk({tag, "_done"}, obs(), word(3'b011, 0, 0));
    tick();
    chk({tag, "_idle"}, obs(), word(3'b000, 0, 0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
    p_x = '0; p_y = '0; q_x = '0; q_y = '0;
    tick(); tick();
    chk("reset", obs(), word(3'b000, 0, 0));
    rst = 1'b0;
    tick();
    chk("post_reset_idle", obs(), word(3'b000, 0, 0));

    // Horizontal line, done at N+6
    begin_line(0, 0, 3, 0);
    exp_pix("h0", 0, 0);
    exp_pix("h1", 1, 0);
    exp_pix("h2", 2, 0);
    exp_pix("h3", 3, 0);
    exp_done("h");

    // Steep line, start pulsed mid-draw with a different line (ignored)
    begin_line(0, 0, 1, 3);
    exp_pix("s0", 0, 0);
    p_x = 10'd8; p_y = 10'd8; q_x = 10'd9; q_y = 10'd9;
    start = 1'b1;
    exp_pix("s1", 0, 1);
    start = 1'b0;
    exp_pix("s2", 1, 2);
    exp_pix("s3", 1, 3);
    exp_done("s");

    // Diagonal toward the origin
    begin_line(5, 5, 2, 2);
    exp_pix("d0", 5, 5);
    exp_pix("d1", 4, 4);
    exp_pix("d2", 3, 3);
    exp_pix("d3", 2, 2);
    exp_done("d");

    // Degenerate line; start asserted in the DONE cycle is ignored
    begin_line(7, 7, 7, 7);
    exp_pix("pt0", 7, 7);
    chk("pt_done", obs(), word(3'b011, 0, 0));
    p_x = 10'd1; p_y = 10'd1; q_x = 10'd2; q_y = 10'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done_ignored", obs(), word(3'b000, 0, 0));
    tick();
    chk("still_idle", obs(), word(3'b000, 0, 0));

    // Shallow line, leftward and downward-y-increasing octant
    begin_line(3, 1, 0, 2);
    exp_pix("o0", 3, 1);
    exp_pix("o1", 2, 1);
    exp_pix("o2", 1, 2);
    exp_pix("o3", 0, 2);
    exp_done("o");

    // Coordinate ceiling
    begin_line(1023, 1023, 1022, 1021);
    exp_pix("m0", 1023, 1023);
    exp_pix("m1", 1022, 1022);
    exp_pix("m2", 1022, 1021);
    exp_done("m");

    // Backpressure on the second pixel
    begin_line(0, 0, 3, 0);
    exp_pix("b0", 0, 0);
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("b_hold", obs(), word(3'b110, 1, 0));
      tick();
    end
    pix_ready = 1'b1;
    exp_pix("b1", 1, 0);
    exp_pix("b2", 2, 0);
    exp_pix("b3", 3, 0);
    exp_done("b");

    // Reset mid-line aborts without a done pulse
    begin_line(0, 0, 9, 0);
    exp_pix("r0", 0, 0);
    exp_pix("r1", 1, 0);
    chk("r2_offered", obs(), word(3'b110, 2, 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_idle", obs(), word(3'b000, 0, 0));
    tick();
    chk("abort_no_done", obs(), word(3'b000, 0, 0));
    begin_line(0, 0, 1, 0);
    exp_pix("a0", 0, 0);
    exp_pix("a1", 1, 0);
    exp_done("a");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
